// File: rtl/mailbox_pkg.sv
// Shared constants and FSM encoding for the CPU mailbox monitor.
// Mailbox layout and terminal values used by the store-bus decoder.
package mailbox_pkg;

   localparam logic [31:0] MB_BASE_ADDR  = 32'h0200_0000;
   localparam logic [31:0] MB_RESULT_OFS = 32'h0000_000C;
   localparam logic [31:0] MB_DONE_OFS   = 32'h0000_0010;
   localparam logic [31:0] DONE_VALUE    = 32'd1;
   localparam int          MB_FIFO_DEPTH = 4;
   localparam int          MB_TIMEOUT    = 100000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE,
      S_TIMEOUT
   } state_e;

endpackage

// File: rtl/mailbox_fifo.sv
// Synchronous result-log FIFO with flush; drops pushes when full
// unless a pop frees a slot in the same cycle.
module mailbox_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q;
   logic [PTR_W-1:0] rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_pop;
   logic             do_push;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem_q[rd_q];

   // Pointer/occupancy update; flush has priority over traffic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clear) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata;
            wr_q        <= wr_q + PTR_W'(1);
         end
         if (do_pop) rd_q <= rd_q + PTR_W'(1);
         if (do_push && !do_pop) cnt_q <= cnt_q + CNT_W'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/cpu_mailbox_monitor.sv
// Snoops the CPU store bus, decodes the software mailbox and
// judges pass/fail with a cycle-count timeout.
module cpu_mailbox_monitor
   import mailbox_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = MB_BASE_ADDR,
   parameter logic [31:0] RESULT_OFS = MB_RESULT_OFS,
   parameter logic [31:0] DONE_OFS   = MB_DONE_OFS,
   parameter int          FIFO_DEPTH = MB_FIFO_DEPTH,
   parameter int          TIMEOUT    = MB_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   input  logic [31:0] expected,
   output logic [31:0] result,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic        overflow,
   output logic [31:0] cycle_count,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   localparam logic [31:0] RES_ADR  = BASE_ADDR + RESULT_OFS;
   localparam logic [31:0] DONE_ADR = BASE_ADDR + DONE_OFS;
   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

   state_e      state_q;
   logic [31:0] result_q;
   logic [31:0] cnt_q;
   logic [31:0] cnt_d;
   logic        match_q;
   logic        done_q;
   logic        pass_q;
   logic        fail_q;
   logic        to_q;
   logic        ovf_q;

   logic res_st;
   logic done_st;
   logic fifo_push;
   logic fifo_clear;
   logic fifo_full;
   logic fifo_empty;

   assign res_st  = MemWrite && (DataAdr == RES_ADR);
   assign done_st = MemWrite && (DataAdr == DONE_ADR) &&
                    (WriteData == DONE_VALUE);

   assign fifo_push  = run && (state_q == S_RUN) && res_st;
   assign fifo_clear = !run || (state_q == S_IDLE);
   assign cnt_d      = cnt_q + 32'd1;

   mailbox_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_log (
      .clk   (clk),
      .reset (reset),
      .clear (fifo_clear),
      .push  (fifo_push),
      .pop   (out_ready),
      .wdata (WriteData),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Mailbox FSM with registered status; run=0 always returns to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         cnt_q    <= '0;
         match_q  <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         to_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (!run) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         cnt_q    <= '0;
         match_q  <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         to_q     <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q  <= S_RUN;
               result_q <= '0;
               cnt_q    <= '0;
               match_q  <= 1'b0;
               done_q   <= 1'b0;
               pass_q   <= 1'b0;
               fail_q   <= 1'b0;
               to_q     <= 1'b0;
               ovf_q    <= 1'b0;
            end
            S_RUN: begin
               cnt_q <= cnt_d;
               if (res_st) begin
                  result_q <= WriteData;
                  match_q  <= match_q | (WriteData == expected);
                  if (fifo_full && !out_ready) ovf_q <= 1'b1;
               end
               if (done_st) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  pass_q  <= match_q;
                  fail_q  <= !match_q;
               end else if (cnt_q == TO_LAST) begin
                  state_q <= S_TIMEOUT;
                  to_q    <= 1'b1;
                  fail_q  <= 1'b1;
               end
            end
            S_DONE, S_TIMEOUT: state_q <= state_q;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign result      = result_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = to_q;
   assign overflow    = ovf_q;
   assign cycle_count = cnt_q;
   assign out_valid   = !fifo_empty;

endmodule

// File: tb/tb_cpu_mailbox_monitor.sv
// Self-checking bench: directed mailbox scenarios plus random store
// traffic, compared every cycle against a queue-based model.
module tb_cpu_mailbox_monitor;

   localparam logic [31:0] RES_A  = 32'h0200_000C;
   localparam logic [31:0] DONE_A = 32'h0200_0010;
   localparam logic [31:0] BASE_A = 32'h0200_0000;
   localparam int          DEPTH  = 4;
   localparam int          TO     = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] expected;
   logic [31:0] result;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;
   logic        overflow;
   logic [31:0] cycle_count;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   int checks = 0;
   int errors = 0;

   // model state
   int          m_phase;
   logic [31:0] m_result;
   int unsigned m_cnt;
   logic        m_match;
   logic        m_done;
   logic        m_pass;
   logic        m_fail;
   logic        m_to;
   logic        m_ovf;
   logic [31:0] m_q[$];

   always #5 clk = ~clk;

   cpu_mailbox_monitor #(
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .MemWrite    (MemWrite),
      .DataAdr     (DataAdr),
      .WriteData   (WriteData),
      .expected    (expected),
      .result      (result),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout),
      .overflow    (overflow),
      .cycle_count (cycle_count),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic model_clear();
      m_result = '0;
      m_cnt    = 0;
      m_match  = 1'b0;
      m_done   = 1'b0;
      m_pass   = 1'b0;
      m_fail   = 1'b0;
      m_to     = 1'b0;
      m_ovf    = 1'b0;
      m_q.delete();
   endtask

   task automatic model_edge();
      if (reset || !run) begin
         model_clear();
         m_phase = 0;
         return;
      end
      if (m_phase == 0) begin
         model_clear();
         m_phase = 1;
         return;
      end
      if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_phase == 1) begin
         m_cnt++;
         if (MemWrite && DataAdr == RES_A) begin
            m_result = WriteData;
            if (m_q.size() < DEPTH) m_q.push_back(WriteData);
            else m_ovf = 1'b1;
            if (WriteData == expected) m_match = 1'b1;
         end else if (MemWrite && DataAdr == DONE_A &&
                      WriteData == 32'd1) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_pass  = m_match;
            m_fail  = !m_match;
         end
         if (m_phase == 1 && m_cnt == TO) begin
            m_phase = 2;
            m_to    = 1'b1;
            m_fail  = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [31:0] head;
      head = (m_q.size() > 0) ? m_q[0] : 32'd0;
      chk("result",      result,           m_result);
      chk("done",        32'(done),        32'(m_done));
      chk("pass",        32'(pass),        32'(m_pass));
      chk("fail",        32'(fail),        32'(m_fail));
      chk("timeout",     32'(timeout),     32'(m_to));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("cycle_count", cycle_count,      m_cnt);
      chk("out_valid",   32'(out_valid),   32'(m_q.size() > 0));
      chk("out_data",    out_data,         head);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      DataAdr   = a;
      WriteData = d;
      step();
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
   endtask

   task automatic restart();
      run = 1'b0;
      step();
      run = 1'b1;
      step();
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      run       = 1'b0;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
      expected  = 32'd89;
      out_ready = 1'b0;
      m_phase   = 0;
      model_clear();
      #1;
      compare_all();
      step();
      reset = 1'b0;
      step();

      // 1: correct result then done flag
      store(BASE_A, 32'd5);
      store(BASE_A + 32'h4, 32'd6);
      store(BASE_A + 32'h8, 32'd15);
      run = 1'b1;
      step();
      store(RES_A, 32'd89);
      store(DONE_A, 32'd1);
      chk("t1_result", result, 32'd89);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_pass", 32'(pass), 32'd1);
      chk("t1_fail", 32'(fail), 32'd0);
      chk("t1_out_data", out_data, 32'd89);
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      store(RES_A, 32'd7);
      chk("t1_held", result, 32'd89);

      // 2: wrong result
      restart();
      store(RES_A, 32'd88);
      store(DONE_A, 32'd1);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_pass", 32'(pass), 32'd0);
      chk("t2_fail", 32'(fail), 32'd1);

      // 3: bad done value, then timeout
      restart();
      store(DONE_A, 32'd2);
      chk("t3_nodone", 32'(done), 32'd0);
      n = 0;
      while (!m_to && n < 2 * TO) begin
         step();
         n++;
      end
      chk("t3_timeout", 32'(timeout), 32'd1);
      chk("t3_fail", 32'(fail), 32'd1);
      chk("t3_count", cycle_count, 32'd50);
      step();
      chk("t3_frozen", cycle_count, 32'd50);

      // 4: overflow then drain
      restart();
      for (int i = 1; i <= 5; i++) store(RES_A, 32'(i));
      chk("t4_overflow", 32'(overflow), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("t4_head", out_data, 32'(i));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
      chk("t4_empty", 32'(out_valid), 32'd0);

      // 5: push and pop together when full
      restart();
      for (int i = 1; i <= 4; i++) store(RES_A, 32'(i));
      out_ready = 1'b1;
      store(RES_A, 32'd9);
      out_ready = 1'b0;
      chk("t5_no_ovf", 32'(overflow), 32'd0);
      chk("t5_head", out_data, 32'd2);
      for (int i = 0; i < 3; i++) begin
         out_ready = 1'b1;
         step();
      end
      out_ready = 1'b0;
      chk("t5_tail", out_data, 32'd9);

      // 6: async reset mid-run, then IDLE preload ignored
      restart();
      store(RES_A, 32'd33);
      #2;
      reset = 1'b1;
      #1;
      model_clear();
      m_phase = 0;
      compare_all();
      chk("t6_result0", result, 32'd0);
      step();
      reset = 1'b0;
      run   = 1'b0;
      store(RES_A, 32'h1234);
      chk("t6_preload", result, 32'd0);
      chk("t6_valid", 32'(out_valid), 32'd0);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         int sel;
         run       = ($urandom_range(0, 39) != 0);
         MemWrite  = ($urandom_range(0, 2) == 0);
         sel       = int'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) == 0);
         expected  = 32'd89;
         case (sel)
            0:       DataAdr = RES_A;
            1:       DataAdr = DONE_A;
            2:       DataAdr = BASE_A;
            default: DataAdr = $urandom;
         endcase
         if (sel == 1) WriteData = $urandom_range(0, 2);
         else if ($urandom_range(0, 3) == 0) WriteData = 32'd89;
         else WriteData = $urandom_range(0, 99);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
